// File: rtl/ser_dispatcher.sv
// ser_dispatcher: dispatch stage between fetch and a bank of serializer engines.
// Fetched table entries are queued in a FIFO. The FIFO head goes to one idle,
// ready engine per cycle, chosen round-robin. Each issue carries the entry's
// absolute address (object base + entry offset).
//
// Ports:
//   clk, reset               clock, async active-high reset
//   en                       dispatch enable (FIFO writes still accepted when low)
//   new_cpp_base_addr[_valid] object base address load
//   in_entry, in_valid       entry from fetch
//   full, occupancy          FIFO status (full -> fetch ob_full)
//   ser_ready, ser_done      per-engine idle / finished pulse
//   ser_entry, ser_addr      per-engine issued entry and absolute address
//   ser_entry_valid          per-engine one-cycle issue pulse
//   done                     FIFO empty and no engine busy

package ser_dispatcher_pkg;
  typedef struct packed {
    logic [15:0] field_id;
    logic [15:0] length;
    logic [31:0] offset;
  } table_entry_t;
endpackage

// Per-engine issue register and busy flag.
module ser_dispatcher_lane
  import ser_dispatcher_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         issue,
  input  table_entry_t issue_entry,
  input  logic [63:0]  issue_addr,
  input  logic         ser_done,
  output table_entry_t ser_entry,
  output logic [63:0]  ser_addr,
  output logic         ser_entry_valid,
  output logic         busy
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ser_entry       <= '0;
      ser_addr        <= '0;
      ser_entry_valid <= 1'b0;
      busy            <= 1'b0;
    end else begin
      ser_entry_valid <= issue;
      if (issue) begin
        ser_entry <= issue_entry;
        ser_addr  <= issue_addr;
      end
      // issue only targets an idle lane, and done on an idle lane is a no-op,
      // so the two terms never fight.
      busy <= issue | (busy & ~ser_done);
    end
  end
endmodule

module ser_dispatcher
  import ser_dispatcher_pkg::*;
#(
  parameter int NUM_SER = 2,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [63:0]                   new_cpp_base_addr,
  input  logic                          new_cpp_base_addr_valid,
  input  table_entry_t                  in_entry,
  input  logic                          in_valid,
  output logic                          full,
  output logic [CNT_W-1:0]              occupancy,
  input  logic [NUM_SER-1:0]            ser_ready,
  input  logic [NUM_SER-1:0]            ser_done,
  output table_entry_t [NUM_SER-1:0]    ser_entry,
  output logic [NUM_SER-1:0][63:0]      ser_addr,
  output logic [NUM_SER-1:0]            ser_entry_valid,
  output logic                          done
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = (NUM_SER > 1) ? $clog2(NUM_SER) : 1;

  table_entry_t         mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [63:0]          base;
  logic [RW-1:0]        rr_ptr;
  logic [NUM_SER-1:0]   busy, elig, grant;
  logic [RW-1:0]        grant_idx;
  logic                 issue_any, push, empty;
  table_entry_t         head;
  logic [63:0]          head_addr;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign occupancy = count;
  assign done      = empty & ~|busy;
  // full comes from registered count, so a same-cycle pop never admits a push.
  assign push      = in_valid & ~full;
  assign head      = mem[rd_ptr];
  assign head_addr = base + 64'(head.offset);
  assign elig      = {NUM_SER{en & ~empty}} & ~busy & ser_ready;

  // Round-robin: first eligible engine at or after rr_ptr, wrapping.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    issue_any = 1'b0;
    for (int k = 0; k < NUM_SER; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NUM_SER;
      if (!issue_any && elig[idx]) begin
        issue_any  = 1'b1;
        grant_idx  = RW'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      base   <= '0;
      rr_ptr <= '0;
    end else begin
      if (push)      wr_ptr <= wr_ptr + 1'b1;
      if (issue_any) rd_ptr <= rd_ptr + 1'b1;
      case ({push, issue_any})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Issue this cycle already sampled the old base through head_addr.
      if (new_cpp_base_addr_valid) base <= new_cpp_base_addr;
      if (issue_any)
        rr_ptr <= (int'(grant_idx) == NUM_SER - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_SER; i++) begin : g_lane
    ser_dispatcher_lane u_lane (
      .clk             (clk),
      .reset           (reset),
      .issue           (grant[i]),
      .issue_entry     (head),
      .issue_addr      (head_addr),
      .ser_done        (ser_done[i]),
      .ser_entry       (ser_entry[i]),
      .ser_addr        (ser_addr[i]),
      .ser_entry_valid (ser_entry_valid[i]),
      .busy            (busy[i])
    );
  end
endmodule

// File: tb/tb_ser_dispatcher.sv
// Directed bench for ser_dispatcher with NUM_SER=2, DEPTH=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ser_dispatcher;
  import ser_dispatcher_pkg::*;
  localparam int NS = 2;
  localparam int D  = 8;
  localparam int CW = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                en;
  logic [63:0]         nb;
  logic                nbv;
  table_entry_t        in_entry;
  logic                in_valid;
  logic                full;
  logic [CW-1:0]       occupancy;
  logic [NS-1:0]       ser_ready, ser_done;
  table_entry_t [NS-1:0] ser_entry;
  logic [NS-1:0][63:0] ser_addr;
  logic [NS-1:0]       ser_entry_valid;
  logic                done;

  int passed = 0;
  int total  = 0;

  ser_dispatcher #(.NUM_SER(NS), .DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .en(en),
    .new_cpp_base_addr(nb), .new_cpp_base_addr_valid(nbv),
    .in_entry(in_entry), .in_valid(in_valid),
    .full(full), .occupancy(occupancy),
    .ser_ready(ser_ready), .ser_done(ser_done),
    .ser_entry(ser_entry), .ser_addr(ser_addr),
    .ser_entry_valid(ser_entry_valid), .done(done)
  );

  always #5 clk = ~clk;

  function automatic table_entry_t mk(input logic [31:0] off);
    table_entry_t e;
    e.offset   = off;
    e.length   = 16'h0040;
    e.field_id = off[15:0] ^ 16'h5a5a;
    return e;
  endfunction

  task automatic idle_inputs();
    en = 1'b1; nb = '0; nbv = 1'b0; in_valid = 1'b0; in_entry = '0;
    ser_ready = 2'b11; ser_done = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    total++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else passed++;
    total++; if (occupancy !== 4'd0) $display("FAIL reset_occ: got %0d want 0", occupancy); else passed++;
    total++; if (done !== 1'b1) $display("FAIL reset_done: got %b want 1", done); else passed++;
    total++; if (ser_entry_valid !== 2'b00) $display("FAIL reset_valid: got %b want 00", ser_entry_valid); else passed++;
    total++; if (ser_entry !== '0) $display("FAIL reset_entry: got %h want 0", ser_entry); else passed++;
    total++; if (ser_addr !== '0) $display("FAIL reset_addr: got %h want 0", ser_addr); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    nb = 64'h1000; nbv = 1'b1; in_entry = mk(32'h10); in_valid = 1'b1;
    @(negedge clk);
    nbv = 1'b0; in_valid = 1'b0;
    total++; if (occupancy !== 4'd1) $display("FAIL single_occ: got %0d want 1", occupancy); else passed++;
    total++; if (ser_entry_valid !== 2'b00) $display("FAIL single_early: got %b want 00", ser_entry_valid); else passed++;
    total++; if (done !== 1'b0) $display("FAIL single_done_low: got %b want 0", done); else passed++;
    @(negedge clk);
    total++; if (ser_entry_valid !== 2'b01) $display("FAIL single_valid: got %b want 01", ser_entry_valid); else passed++;
    total++; if (ser_addr[0] !== 64'h1010) $display("FAIL single_addr: got %h want 1010", ser_addr[0]); else passed++;
    total++; if (ser_entry[0] !== mk(32'h10)) $display("FAIL single_entry: got %h want %h", ser_entry[0], mk(32'h10)); else passed++;
    @(negedge clk);
    total++; if (ser_entry_valid !== 2'b00) $display("FAIL single_pulse: got %b want 00", ser_entry_valid); else passed++;
    total++; if (done !== 1'b0) $display("FAIL single_busy: got %b want 0", done); else passed++;
    ser_done = 2'b01;
    @(negedge clk);
    ser_done = 2'b00;
    total++; if (done !== 1'b1) $display("FAIL single_done_back: got %b want 1", done); else passed++;
  endtask

  task automatic test_round_robin();
    int eng_got[4];
    logic [31:0] off_got[4];
    int n = 0;
    int cd[2] = '{0, 0};
    logic [1:0] nd;
    do_reset();
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (cyc < 4) begin in_valid = 1'b1; in_entry = mk(32'h20 + cyc); end
      else in_valid = 1'b0;
      @(negedge clk);
      nd = 2'b00;
      for (int i = 0; i < NS; i++) begin
        if (cd[i] > 0) begin cd[i]--; if (cd[i] == 0) nd[i] = 1'b1; end
        if (ser_entry_valid[i]) begin
          if (n < 4) begin eng_got[n] = i; off_got[n] = ser_entry[i].offset; end
          n++;
          cd[i] = 2;
        end
      end
      ser_done = nd;
    end
    ser_done = 2'b00; in_valid = 1'b0;
    total++; if (n !== 4) $display("FAIL rr_count: got %0d want 4", n); else passed++;
    for (int k = 0; k < 4; k++) begin
      total++; if (eng_got[k] !== k % 2) $display("FAIL rr_engine[%0d]: got %0d want %0d", k, eng_got[k], k % 2); else passed++;
      total++; if (off_got[k] !== 32'h20 + k) $display("FAIL rr_offset[%0d]: got %h want %h", k, off_got[k], 32'h20 + k); else passed++;
    end
    @(negedge clk);
    total++; if (done !== 1'b1) $display("FAIL rr_done: got %b want 1", done); else passed++;
  endtask

  task automatic test_full();
    logic [31:0] off_got[8];
    int n = 0;
    do_reset();
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_entry = mk(32'h100 + k);
      @(negedge clk);
      if (k == 6) begin
        total++; if (full !== 1'b0) $display("FAIL full_at7: got %b want 0", full); else passed++;
      end
      if (k == 7) begin
        total++; if (full !== 1'b1) $display("FAIL full_at8: got %b want 1", full); else passed++;
        total++; if (occupancy !== 4'd8) $display("FAIL full_occ8: got %0d want 8", occupancy); else passed++;
      end
    end
    in_valid = 1'b0;
    total++; if (occupancy !== 4'd8) $display("FAIL full_ignored: got %0d want 8", occupancy); else passed++;
    total++; if (ser_entry_valid !== 2'b00) $display("FAIL full_en_low: got %b want 00", ser_entry_valid); else passed++;
    en = 1'b1;
    for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
      @(negedge clk);
      ser_done = 2'b00;
      for (int i = 0; i < NS; i++) begin
        if (ser_entry_valid[i]) begin
          if (n < 8) off_got[n] = ser_entry[i].offset;
          n++;
          ser_done[i] = 1'b1;
        end
      end
    end
    @(negedge clk);
    ser_done = 2'b00;
    total++; if (n !== 8) $display("FAIL drain_count: got %0d want 8", n); else passed++;
    for (int k = 0; k < 8; k++) begin
      total++; if (off_got[k] !== 32'h100 + k) $display("FAIL drain_order[%0d]: got %h want %h", k, off_got[k], 32'h100 + k); else passed++;
    end
    @(negedge clk);
    total++; if (occupancy !== 4'd0) $display("FAIL drain_occ: got %0d want 0", occupancy); else passed++;
    total++; if (full !== 1'b0) $display("FAIL drain_full: got %b want 0", full); else passed++;
    total++; if (done !== 1'b1) $display("FAIL drain_done: got %b want 1", done); else passed++;
  endtask

  task automatic test_base_race();
    do_reset();
    nb = 64'h1000; nbv = 1'b1; in_valid = 1'b1; in_entry = mk(32'h4);
    @(negedge clk);
    nb = 64'h2000; nbv = 1'b1; in_valid = 1'b1; in_entry = mk(32'h8);
    @(negedge clk);
    nbv = 1'b0; in_valid = 1'b0;
    total++; if (ser_entry_valid !== 2'b01) $display("FAIL race_valid0: got %b want 01", ser_entry_valid); else passed++;
    total++; if (ser_addr[0] !== 64'h1004) $display("FAIL race_old_base: got %h want 1004", ser_addr[0]); else passed++;
    @(negedge clk);
    total++; if (ser_entry_valid !== 2'b10) $display("FAIL race_valid1: got %b want 10", ser_entry_valid); else passed++;
    total++; if (ser_addr[1] !== 64'h2008) $display("FAIL race_new_base: got %h want 2008", ser_addr[1]); else passed++;
    ser_done = 2'b11;
    @(negedge clk);
    ser_done = 2'b00;
  endtask

  task automatic test_wrap_spurious();
    do_reset();
    ser_done = 2'b11;
    @(negedge clk);
    total++; if (done !== 1'b1) $display("FAIL spur_idle_done: got %b want 1", done); else passed++;
    nb = 64'hFFFF_FFFF_FFFF_FFF8; nbv = 1'b1; in_valid = 1'b1; in_entry = mk(32'h10); ser_done = 2'b10;
    @(negedge clk);
    nbv = 1'b0; in_valid = 1'b0; ser_done = 2'b00;
    total++; if (done !== 1'b0) $display("FAIL wrap_queued: got %b want 0", done); else passed++;
    @(negedge clk);
    total++; if (ser_entry_valid !== 2'b01) $display("FAIL wrap_valid: got %b want 01", ser_entry_valid); else passed++;
    total++; if (ser_addr[0] !== 64'h8) $display("FAIL wrap_addr: got %h want 8", ser_addr[0]); else passed++;
    ser_done = 2'b10; in_valid = 1'b1; in_entry = mk(32'h20);
    @(negedge clk);
    ser_done = 2'b00; in_valid = 1'b0;
    total++; if (done !== 1'b0) $display("FAIL spur_busy_done: got %b want 0", done); else passed++;
    @(negedge clk);
    total++; if (ser_entry_valid !== 2'b10) $display("FAIL spur_eng1_free: got %b want 10", ser_entry_valid); else passed++;
    total++; if (ser_addr[1] !== 64'h18) $display("FAIL wrap_addr1: got %h want 18", ser_addr[1]); else passed++;
    ser_done = 2'b11;
    @(negedge clk);
    ser_done = 2'b00;
    total++; if (done !== 1'b1) $display("FAIL wrap_done: got %b want 1", done); else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    ser_ready = 2'b00;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_entry = mk(32'h300 + k);
      @(negedge clk);
    end
    in_valid = 1'b0; ser_ready = 2'b11;
    total++; if (occupancy !== 4'd5) $display("FAIL ar_occ5: got %0d want 5", occupancy); else passed++;
    @(negedge clk);
    @(negedge clk);
    total++; if (ser_entry_valid !== 2'b10) $display("FAIL ar_pre_valid: got %b want 10", ser_entry_valid); else passed++;
    total++; if (occupancy !== 4'd3) $display("FAIL ar_occ3: got %0d want 3", occupancy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL ar_pre_done: got %b want 0", done); else passed++;
    #2 reset = 1'b1;
    #1;
    total++; if (ser_entry_valid !== 2'b00) $display("FAIL ar_valid: got %b want 00", ser_entry_valid); else passed++;
    total++; if (occupancy !== 4'd0) $display("FAIL ar_occ: got %0d want 0", occupancy); else passed++;
    total++; if (full !== 1'b0) $display("FAIL ar_full: got %b want 0", full); else passed++;
    total++; if (done !== 1'b1) $display("FAIL ar_done: got %b want 1", done); else passed++;
    total++; if (ser_addr !== '0) $display("FAIL ar_addr: got %h want 0", ser_addr); else passed++;
    total++; if (ser_entry !== '0) $display("FAIL ar_entry: got %h want 0", ser_entry); else passed++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_base_race();
    test_wrap_spurious();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
